nt_trigger_monitor: RTL and testbench
=====================================

Name: nt_trigger_monitor

Overview:
- Downstream consumer of the single-bit node output I8479 produced by the Nt_Node subcircuit stage.
- Samples the I8479 bit stream and keeps a shift history.
- Matches the history against a programmable masked rare-value pattern and counts matches per observation window.
- Raises a sticky trojan-trigger alarm when the count reaches a threshold. Feeds the detection-data collection logic.

Parameters:
- PAT_W, 4, history/pattern width in samples (2..16)
- CNT_W, 8, match counter width
- WIN_LEN, 16, samples per observation window (>= PAT_W)

Ports:
- I1470  input  1  clock, all state updates on the rising edge
- I1477  input  1  reset, synchronous, active-low
- I8479  input  1  node output bit from the upstream subcircuit
- sample_en  input  1  sample I8479 this cycle
- clear  input  1  synchronous soft clear of all monitor state
- pattern  input  PAT_W  target sequence; bit 0 = newest sample
- mask  input  PAT_W  1 = compare this bit, 0 = don't-care
- threshold  input  CNT_W  matches per window that trigger the alarm; 0 = alarm disabled
- match  output  1  registered one-cycle pulse on a pattern hit
- match_count  output  CNT_W  matches in the current window
- alarm  output  1  sticky trigger flag
- state  output  2  FSM state: 0 IDLE, 1 ARMED, 2 ALARM

Behaviour:
- Reset (I1477 = 0 at a clock edge):
  - history = 0, fill = 0, window count = 0
  - match = 0, match_count = 0, alarm = 0, state = IDLE
  - Reset has priority over every other input.
- History update: on a sample_en cycle, H <= {H[PAT_W-2:0], I8479}.
- Fill counter: increments on each sample, saturating at PAT_W.
- Hit condition: hit = sample_en && fill_next == PAT_W && ((H_next ^ pattern) & mask) == 0.
  - match is registered, so it asserts the cycle after the sample edge (latency 1).
  - mask = 0 means every full-history sample is a hit.
- match_count:
  - +1 on each hit, saturating at 2^CNT_W-1.
  - Window counter increments on each sample and wraps from WIN_LEN-1 to 0.
  - On the wrap sample: if ALARM is not triggered by that sample, match_count <= 0. The hit on the wrap sample is evaluated for the alarm first, then discarded.
- FSM:
  - IDLE -> ARMED when fill reaches PAT_W.
  - ARMED -> ALARM when threshold != 0 and match_count_next >= threshold.
  - ALARM is held until clear or reset. In ALARM, match_count freezes: no increment and no window clear. History continues shifting and match still pulses.
- Outputs: alarm = (state == ALARM), registered. match_count and state are registered.
- clear = 1:
  - Same effect as reset except pattern, mask and threshold are inputs and are not affected.
  - Overrides a simultaneous sample_en: the sample is dropped and no match is produced.
- Threshold changes: take effect on the next sample. A threshold lowered below the current match_count triggers ALARM on the next hit, not immediately.
- No X propagation: all registers have defined reset values.

Decomposition:
- Shared package nt_mon_pkg:
  - state encoding constants ST_IDLE = 2'd0, ST_ARMED = 2'd1, ST_ALARM = 2'd2
  - default PAT_W/CNT_W/WIN_LEN values
- One natural sub-module: nt_hist_shifter, containing the PAT_W shift register, the fill counter, and the masked comparator that produces hit.
- The top level holds the counters and the FSM.

Test Plan (PAT_W=4, CNT_W=8, WIN_LEN=16, pattern=4'b1011, mask=4'hF, threshold=3):
- Reset/fill: release I1477 and sample 1,0,1,1 (oldest first).
  - state is IDLE for the first 3 samples and ARMED after the 4th.
  - match pulses once, 1 cycle after the 4th sample edge; match_count = 1.
- Threshold alarm: stream 1011 repeated 3 times within one window.
  - alarm rises the cycle after the 3rd hit; match_count = 3.
  - Further hits keep match pulsing while match_count stays 3.
- Window expiry: 2 hits, then zeros until 16 samples in total.
  - match_count returns to 0 after the 16th sample; no alarm.
  - A hit on the 16th sample with count 2 raises alarm and count = 3.
- Mask/don't-care: mask = 4'b1001, stream 1,1,0,1 -> hit.
  - mask = 4'hF with the same stream -> no hit.
  - threshold = 0 with 10 hits -> alarm stays 0 and match_count = 10.
- Clear priority:
  - In ALARM, assert clear with sample_en = 1 -> next cycle alarm = 0, state = IDLE, match_count = 0, and no match pulse.
  - Reset mid-window behaves identically.
- Saturation: CNT_W = 2, threshold = 0, 5 hits in one window -> match_count holds at 3.

Source files
------------

// File: rtl/nt_mon_pkg.sv
// nt_mon_pkg: shared state encoding and default sizing for the trigger monitor
package nt_mon_pkg;
    localparam int PAT_W_DEF   = 4;
    localparam int CNT_W_DEF   = 8;
    localparam int WIN_LEN_DEF = 16;
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_ALARM = 2'd2
    } mon_state_e;
endpackage

// File: rtl/nt_hist_shifter.sv
// nt_hist_shifter: sample history, fill tracking and masked pattern compare
module nt_hist_shifter #(
    parameter int PAT_W = 4
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clear_i,
    input  logic             sample_i,
    input  logic             bit_i,
    input  logic [PAT_W-1:0] pattern_i,
    input  logic [PAT_W-1:0] mask_i,
    output logic             hit_o,
    output logic             full_o
);
    localparam int FW = $clog2(PAT_W + 1);
    logic [PAT_W-1:0] hist_q, hist_d;
    logic [FW-1:0]    fill_q, fill_d;
    always_comb begin
        hist_d = clear_i ? '0 : sample_i ? {hist_q[PAT_W-2:0], bit_i} : hist_q;
        fill_d = clear_i ? '0 : (sample_i && fill_q != FW'(PAT_W)) ? fill_q + 1'b1 : fill_q;
    end
    assign full_o = fill_d == FW'(PAT_W);
    // Compare against the history including this cycle's sample
    assign hit_o  = sample_i && !clear_i && full_o && (((hist_d ^ pattern_i) & mask_i) == '0);
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            hist_q <= '0;
            fill_q <= '0;
        end else begin
            hist_q <= hist_d;
            fill_q <= fill_d;
        end
    end
endmodule

// File: rtl/nt_trigger_monitor.sv
// nt_trigger_monitor: counts rare-pattern hits on I8479 per window and raises a sticky alarm
module nt_trigger_monitor
    import nt_mon_pkg::*;
#(
    parameter int PAT_W   = PAT_W_DEF,
    parameter int CNT_W   = CNT_W_DEF,
    parameter int WIN_LEN = WIN_LEN_DEF
) (
    input  logic             I1470,
    input  logic             I1477,
    input  logic             I8479,
    input  logic             sample_en,
    input  logic             clear,
    input  logic [PAT_W-1:0] pattern,
    input  logic [PAT_W-1:0] mask,
    input  logic [CNT_W-1:0] threshold,
    output logic             match,
    output logic [CNT_W-1:0] match_count,
    output logic             alarm,
    output logic [1:0]       state
);
    localparam int WW = $clog2(WIN_LEN);
    logic             smp, hit, full, wrap, trig;
    logic [WW-1:0]    win_q, win_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
    logic             match_q;
    mon_state_e       state_q, state_d;
    nt_hist_shifter #(.PAT_W(PAT_W)) u_hist (
        .clk_i     (I1470),
        .rst_ni    (I1477),
        .clear_i   (clear),
        .sample_i  (sample_en),
        .bit_i     (I8479),
        .pattern_i (pattern),
        .mask_i    (mask),
        .hit_o     (hit),
        .full_o    (full)
    );
    assign smp     = sample_en && !clear;
    assign wrap    = smp && win_q == WW'(WIN_LEN - 1);
    assign cnt_inc = (hit && cnt_q != '1) ? cnt_q + 1'b1 : cnt_q;
    // Only a hit can trigger, so a lowered threshold waits for the next hit
    assign trig    = hit && state_q != ST_ALARM && threshold != '0 && cnt_inc >= threshold;
    always_comb begin
        win_d   = (clear || wrap) ? '0 : smp ? win_q + 1'b1 : win_q;
        cnt_d   = clear ? '0 : state_q == ST_ALARM ? cnt_q : trig ? cnt_inc : wrap ? '0 : cnt_inc;
        state_d = clear ? ST_IDLE
                : trig ? ST_ALARM
                : (state_q == ST_IDLE && full) ? ST_ARMED
                : state_q;
    end
    always_ff @(posedge I1470) begin
        if (!I1477) begin
            win_q   <= '0;
            cnt_q   <= '0;
            match_q <= 1'b0;
            state_q <= ST_IDLE;
        end else begin
            win_q   <= win_d;
            cnt_q   <= cnt_d;
            match_q <= hit;
            state_q <= state_d;
        end
    end
    assign match       = match_q;
    assign match_count = cnt_q;
    assign alarm       = state_q == ST_ALARM;
    assign state       = state_q;
endmodule

// File: tb/tb_nt_trigger_monitor.sv
// tb_nt_trigger_monitor: directed checks of fill, alarm, window, mask, clear and saturation
module tb_nt_trigger_monitor;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       din = 1'b0;
    logic       sample_en = 1'b0;
    logic       clear = 1'b0;
    logic [3:0] pattern = 4'b1011;
    logic [3:0] mask = 4'hF;
    logic [7:0] thr = 8'd3;
    logic       match, alarm, match2, alarm2;
    logic [7:0] cnt;
    logic [1:0] cnt2, state, state2;
    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    nt_trigger_monitor #(.PAT_W(4), .CNT_W(8), .WIN_LEN(16)) dut (
        .I1470(clk), .I1477(rst_n), .I8479(din), .sample_en(sample_en), .clear(clear),
        .pattern(pattern), .mask(mask), .threshold(thr),
        .match(match), .match_count(cnt), .alarm(alarm), .state(state)
    );

    nt_trigger_monitor #(.PAT_W(4), .CNT_W(2), .WIN_LEN(16)) dut2 (
        .I1470(clk), .I1477(rst_n), .I8479(din), .sample_en(sample_en), .clear(clear),
        .pattern(pattern), .mask(mask), .threshold(thr[1:0]),
        .match(match2), .match_count(cnt2), .alarm(alarm2), .state(state2)
    );

    task automatic do_reset();
        rst_n = 1'b0; clear = 1'b0; sample_en = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    task automatic smp(input logic b);
        sample_en = 1'b1; din = b;
        @(posedge clk); #1;
        sample_en = 1'b0;
    endtask

    task automatic seq(input logic [15:0] v, input int n);
        for (int i = n - 1; i >= 0; i--) smp(v[i]);
    endtask

    task automatic test_reset();
        pattern = 4'b1011; mask = 4'hF; thr = 8'd3;
        do_reset();
        checks++; if (state !== 2'd0) begin failures++; $display("FAIL reset_state got=%0d exp=0", state); end
        checks++; if (alarm !== 1'b0) begin failures++; $display("FAIL reset_alarm got=%b exp=0", alarm); end
        checks++; if (cnt !== 8'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", cnt); end
        checks++; if (match !== 1'b0) begin failures++; $display("FAIL reset_match got=%b exp=0", match); end
    endtask

    task automatic test_fill();
        smp(1'b1);
        checks++; if (state !== 2'd0) begin failures++; $display("FAIL fill1_state got=%0d exp=0", state); end
        smp(1'b0);
        checks++; if (state !== 2'd0) begin failures++; $display("FAIL fill2_state got=%0d exp=0", state); end
        smp(1'b1);
        checks++; if (state !== 2'd0 || match !== 1'b0) begin failures++; $display("FAIL fill3 state=%0d match=%b exp=0,0", state, match); end
        smp(1'b1);
        checks++; if (state !== 2'd1) begin failures++; $display("FAIL fill4_state got=%0d exp=1", state); end
        checks++; if (match !== 1'b1 || cnt !== 8'd1) begin failures++; $display("FAIL fill4_hit match=%b cnt=%0d exp=1,1", match, cnt); end
    endtask

    task automatic test_alarm();
        seq(16'b011, 3);
        checks++; if (match !== 1'b1 || cnt !== 8'd2 || alarm !== 1'b0) begin failures++; $display("FAIL alarm_hit2 match=%b cnt=%0d alarm=%b exp=1,2,0", match, cnt, alarm); end
        seq(16'b011, 3);
        checks++; if (alarm !== 1'b1 || state !== 2'd2 || cnt !== 8'd3) begin failures++; $display("FAIL alarm_hit3 alarm=%b state=%0d cnt=%0d exp=1,2,3", alarm, state, cnt); end
        seq(16'b011, 3);
        checks++; if (match !== 1'b1 || cnt !== 8'd3 || alarm !== 1'b1) begin failures++; $display("FAIL alarm_frozen match=%b cnt=%0d alarm=%b exp=1,3,1", match, cnt, alarm); end
        @(posedge clk); #1;
        checks++; if (match !== 1'b0) begin failures++; $display("FAIL alarm_pulse_end got=%b exp=0", match); end
    endtask

    task automatic test_window();
        do_reset();
        seq(16'b1011, 4); seq(16'b011, 3);
        repeat (8) smp(1'b0);
        checks++; if (cnt !== 8'd2) begin failures++; $display("FAIL win_before_wrap got=%0d exp=2", cnt); end
        smp(1'b0);
        checks++; if (cnt !== 8'd0 || alarm !== 1'b0 || state !== 2'd1) begin failures++; $display("FAIL win_wrap cnt=%0d alarm=%b state=%0d exp=0,0,1", cnt, alarm, state); end
        do_reset();
        seq(16'b1011, 4); seq(16'b011, 3);
        repeat (5) smp(1'b0);
        seq(16'b1011, 4);
        checks++; if (alarm !== 1'b1 || cnt !== 8'd3 || match !== 1'b1) begin failures++; $display("FAIL win_wrap_hit alarm=%b cnt=%0d match=%b exp=1,3,1", alarm, cnt, match); end
        smp(1'b0);
        checks++; if (cnt !== 8'd3) begin failures++; $display("FAIL win_after_alarm got=%0d exp=3", cnt); end
    endtask

    task automatic test_mask();
        do_reset();
        mask = 4'b1001;
        seq(16'b1101, 4);
        checks++; if (match !== 1'b1 || cnt !== 8'd1) begin failures++; $display("FAIL mask_dontcare match=%b cnt=%0d exp=1,1", match, cnt); end
        do_reset();
        mask = 4'hF;
        seq(16'b1101, 4);
        checks++; if (match !== 1'b0 || cnt !== 8'd0 || state !== 2'd1) begin failures++; $display("FAIL mask_full match=%b cnt=%0d state=%0d exp=0,0,1", match, cnt, state); end
        do_reset();
        thr = 8'd0; mask = 4'h0;
        repeat (13) smp(1'b0);
        checks++; if (cnt !== 8'd10 || alarm !== 1'b0 || state !== 2'd1) begin failures++; $display("FAIL thr_zero cnt=%0d alarm=%b state=%0d exp=10,0,1", cnt, alarm, state); end
    endtask

    task automatic test_saturation();
        do_reset();
        thr = 8'd0; mask = 4'h0;
        repeat (8) smp(1'b0);
        checks++; if (cnt2 !== 2'd3) begin failures++; $display("FAIL sat_cnt2 got=%0d exp=3", cnt2); end
        checks++; if (cnt !== 8'd5) begin failures++; $display("FAIL sat_cnt8 got=%0d exp=5", cnt); end
    endtask

    task automatic test_thr_lower();
        do_reset();
        thr = 8'd10; mask = 4'h0;
        repeat (8) smp(1'b0);
        thr = 8'd2;
        @(posedge clk); #1;
        checks++; if (alarm !== 1'b0 || state !== 2'd1 || cnt !== 8'd5) begin failures++; $display("FAIL thr_lower_idle alarm=%b state=%0d cnt=%0d exp=0,1,5", alarm, state, cnt); end
        smp(1'b0);
        checks++; if (alarm !== 1'b1 || cnt !== 8'd6) begin failures++; $display("FAIL thr_lower_hit alarm=%b cnt=%0d exp=1,6", alarm, cnt); end
    endtask

    task automatic test_clear();
        do_reset();
        thr = 8'd3; mask = 4'h0;
        repeat (6) smp(1'b0);
        checks++; if (alarm !== 1'b1 || cnt !== 8'd3) begin failures++; $display("FAIL clr_setup alarm=%b cnt=%0d exp=1,3", alarm, cnt); end
        clear = 1'b1; sample_en = 1'b1; din = 1'b0;
        @(posedge clk); #1;
        clear = 1'b0; sample_en = 1'b0;
        checks++; if (alarm !== 1'b0 || state !== 2'd0 || cnt !== 8'd0 || match !== 1'b0) begin failures++; $display("FAIL clr_prio alarm=%b state=%0d cnt=%0d match=%b exp=0,0,0,0", alarm, state, cnt, match); end
        repeat (3) smp(1'b0);
        checks++; if (match !== 1'b0 || state !== 2'd0) begin failures++; $display("FAIL clr_fill match=%b state=%0d exp=0,0", match, state); end
        do_reset();
        repeat (6) smp(1'b0);
        rst_n = 1'b0; sample_en = 1'b1;
        @(posedge clk); #1;
        rst_n = 1'b1; sample_en = 1'b0;
        checks++; if (alarm !== 1'b0 || state !== 2'd0 || cnt !== 8'd0 || match !== 1'b0) begin failures++; $display("FAIL rst_mid alarm=%b state=%0d cnt=%0d match=%b exp=0,0,0,0", alarm, state, cnt, match); end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_alarm();
        test_window();
        test_mask();
        test_saturation();
        test_thr_lower();
        test_clear();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
